// File: rtl/akuma_pkg.sv
// rtl/akuma_pkg.sv - shared types, constants and helpers for the Akuma motion controller
//
// Purpose: character state encoding (doubles as the sprite-set select), per-state
// animation frame counts, screen/sprite geometry and the clamped horizontal step.
// Ports: none (package).
package akuma_pkg;

  localparam int SCREEN_W = 640;
  localparam int SPRITE_W = 140;
  localparam int SPRITE_H = 161;

  localparam logic [2:0] SPR_IDLE   = 3'd0;
  localparam logic [2:0] SPR_WALK   = 3'd1;
  localparam logic [2:0] SPR_CROUCH = 3'd2;
  localparam logic [2:0] SPR_JUMP   = 3'd3;
  localparam logic [2:0] SPR_ATTACK = 3'd4;

  // State values equal the sprite-set codes so sprite_sel is the state register itself.
  typedef enum logic [2:0] {
    ST_IDLE   = SPR_IDLE,
    ST_WALK   = SPR_WALK,
    ST_CROUCH = SPR_CROUCH,
    ST_JUMP   = SPR_JUMP,
    ST_ATTACK = SPR_ATTACK
  } state_e;

  localparam logic [2:0] FRAMES_IDLE   = 3'd4;
  localparam logic [2:0] FRAMES_WALK   = 3'd6;
  localparam logic [2:0] FRAMES_CROUCH = 3'd1;
  localparam logic [2:0] FRAMES_JUMP   = 3'd2;  // counter value unused; jump frame comes from vy
  localparam logic [2:0] FRAMES_ATTACK = 3'd4;

  function automatic logic [2:0] frames_of(input state_e s);
    case (s)
      ST_WALK:   frames_of = FRAMES_WALK;
      ST_CROUCH: frames_of = FRAMES_CROUCH;
      ST_JUMP:   frames_of = FRAMES_JUMP;
      ST_ATTACK: frames_of = FRAMES_ATTACK;
      default:   frames_of = FRAMES_IDLE;
    endcase
  endfunction

  // One horizontal step with saturation at 0 and x_max; no movement unless exactly
  // one direction is requested.
  function automatic logic [9:0] step_x(input logic [9:0] x, input logic go_left,
                                        input logic go_right, input logic [9:0] speed,
                                        input logic [9:0] x_max);
    logic [10:0] sum;
    sum    = {1'b0, x} + {1'b0, speed};
    step_x = x;
    if (go_right && !go_left) begin
      step_x = (sum > {1'b0, x_max}) ? x_max : sum[9:0];
    end else if (go_left && !go_right) begin
      step_x = (x < speed) ? 10'd0 : x - speed;
    end
  endfunction

endpackage

// File: rtl/akuma_anim_counter.sv
// rtl/akuma_anim_counter.sv - animation divider plus frame index counter
//
// Purpose: counts frame ticks; every DIV ticks the frame index advances and wraps at
// frame_cnt_i. clear_i (qualified by tick_i) restarts both counters.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   tick_i          advance enable (one per video frame)
//   clear_i         restart divider and frame index on this tick
//   frame_cnt_i     number of frames in the current sprite set (>=1)
//   frame_o         current frame index
//   wrap_o          this tick would wrap the frame index back to 0
module akuma_anim_counter #(
  parameter int DIV = 6
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       clear_i,
  input  logic [2:0] frame_cnt_i,
  output logic [2:0] frame_o,
  output logic       wrap_o
);

  localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic [2:0]    frame_q, frame_d;
  logic          div_last, frame_last;

  assign div_last   = (div_q == DIV_LAST);
  assign frame_last = (frame_q == frame_cnt_i - 3'd1);
  assign wrap_o     = div_last & frame_last;
  assign frame_o    = frame_q;

  always_comb begin
    div_d   = div_q;
    frame_d = frame_q;
    if (tick_i) begin
      if (clear_i) begin
        div_d   = '0;
        frame_d = 3'd0;
      end else if (div_last) begin
        div_d   = '0;
        frame_d = frame_last ? 3'd0 : frame_q + 3'd1;
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q   <= '0;
      frame_q <= 3'd0;
    end else begin
      div_q   <= div_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: rtl/akuma_move_ctrl.sv
// rtl/akuma_move_ctrl.sv - per-frame motion and animation sequencer for Akuma
//
// Purpose: samples the keys on each frame_tick, runs the idle/walk/crouch/jump/attack
// state machine, integrates jump physics, clamps X to the screen and produces sprite
// position, sprite-set select and animation frame.
// Optional feature: define AKUMA_AIR_CONTROL_EN to steer (and turn) while airborne;
// otherwise the direction is latched at takeoff and facing is frozen in the air.
// Ports:
//   vga_clk, reset_n        pixel clock, asynchronous active-low reset
//   frame_tick              one-cycle pulse per frame; all updates happen on it
//   key_left/right/up/down/atk  control requests
//   AkumaX, AkumaY          sprite origin
//   sprite_sel, anim_frame  sprite set and frame index within it
//   facing_left, airborne   flip request, high while jumping
module akuma_move_ctrl
  import akuma_pkg::*;
#(
  parameter int START_X    = 100,
  parameter int GROUND_Y   = 300,
  parameter int X_MAX      = SCREEN_W - SPRITE_W,
  parameter int WALK_SPEED = 2,
  parameter int JUMP_VEL   = 12,
  parameter int GRAVITY    = 1,
  parameter int ANIM_DIV   = 6
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_atk,
  output logic [9:0] AkumaX,
  output logic [9:0] AkumaY,
  output logic [2:0] sprite_sel,
  output logic [2:0] anim_frame,
  output logic       facing_left,
  output logic       airborne
);

  localparam logic [9:0]        START_XV = 10'(START_X);
  localparam logic [9:0]        GROUND_V = 10'(GROUND_Y);
  localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);
  localparam logic [9:0]        X_MAX_V  = 10'(X_MAX);
  localparam logic [9:0]        SPEED_V  = 10'(WALK_SPEED);
  localparam logic signed [10:0] JUMP_V  = 11'(JUMP_VEL);
  localparam logic signed [10:0] GRAV_V  = 11'(GRAVITY);

  state_e             state_q, state_d;
  logic [9:0]         x_q, x_d;
  logic [9:0]         y_q, y_d;
  logic signed [10:0] vy_q, vy_d;
  logic               facing_q, facing_d;
  logic signed [10:0] y_next;
  logic               go_left, go_right;
  logic               air_left, air_right, air_steer;
  logic [2:0]         anim_q;
  logic               anim_wrap;

  // Both or neither horizontal key cancels out.
  assign go_left  = key_left & ~key_right;
  assign go_right = key_right & ~key_left;

`ifdef AKUMA_AIR_CONTROL_EN
  assign air_left  = go_left;
  assign air_right = go_right;
  assign air_steer = 1'b1;
`else
  logic [1:0] jdir_q, jdir_d;  // {left, right} carried through the jump
  logic       takeoff;

  assign takeoff = frame_tick & ((state_q == ST_IDLE) | (state_q == ST_WALK)) & ~key_atk & key_up;

  // Only a walking takeoff carries momentum; from IDLE the jump is vertical.
  always_comb begin
    jdir_d = jdir_q;
    if (takeoff) jdir_d = (state_q == ST_WALK) ? {go_left, go_right} : 2'b00;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) jdir_q <= 2'b00;
    else          jdir_q <= jdir_d;
  end

  assign air_left  = jdir_q[1];
  assign air_right = jdir_q[0];
  assign air_steer = 1'b0;
`endif

  assign y_next = $signed({1'b0, y_q}) + vy_q;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vy_d     = vy_q;
    facing_d = facing_q;
    if (frame_tick) begin
      unique case (state_q)
        ST_IDLE, ST_WALK: begin
          if (key_atk) begin
            state_d = ST_ATTACK;
          end else if (key_up) begin
            state_d = ST_JUMP;
            vy_d    = -JUMP_V;
          end else if (key_down) begin
            state_d = ST_CROUCH;
          end else if (go_left | go_right) begin
            state_d  = ST_WALK;
            x_d      = step_x(x_q, go_left, go_right, SPEED_V, X_MAX_V);
            facing_d = go_left;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CROUCH: begin
          if (!key_down) state_d = ST_IDLE;
        end
        ST_JUMP: begin
          x_d = step_x(x_q, air_left, air_right, SPEED_V, X_MAX_V);
          if (air_steer && (air_left | air_right)) facing_d = air_left;
          if (y_next >= GROUND_S) begin
            y_d     = GROUND_V;
            vy_d    = '0;
            state_d = ST_IDLE;
          end else begin
            y_d  = y_next[9:0];
            vy_d = vy_q + GRAV_V;
          end
        end
        ST_ATTACK: begin
          if (anim_wrap) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      x_q      <= START_XV;
      y_q      <= GROUND_V;
      vy_q     <= '0;
      facing_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vy_q     <= vy_d;
      facing_q <= facing_d;
    end
  end

  // state_d differs from state_q only on a tick, so this is a tick-qualified clear.
  akuma_anim_counter #(
    .DIV (ANIM_DIV)
  ) u_anim (
    .clk_i       (vga_clk),
    .rst_ni      (reset_n),
    .tick_i      (frame_tick),
    .clear_i     (state_d != state_q),
    .frame_cnt_i (frames_of(state_q)),
    .frame_o     (anim_q),
    .wrap_o      (anim_wrap)
  );

  assign AkumaX      = x_q;
  assign AkumaY      = y_q;
  assign sprite_sel  = state_q;
  // Jump shows rising (0) versus falling/apex (1) instead of the timed sequence.
  assign anim_frame  = (state_q == ST_JUMP) ? (vy_q[10] ? 3'd0 : 3'd1) : anim_q;
  assign facing_left = facing_q;
  assign airborne    = (state_q == ST_JUMP);

endmodule

// File: tb/tb_akuma_move_ctrl.sv
// tb/tb_akuma_move_ctrl.sv - self-checking bench for akuma_move_ctrl
module tb_akuma_move_ctrl;

  localparam int S_IDLE = 0, S_WALK = 1, S_CROUCH = 2, S_JUMP = 3, S_ATTACK = 4;
  localparam int P_START_X = 100, P_GROUND_Y = 300, P_X_MAX = 500;
  localparam int P_SPEED = 2, P_JUMP_VEL = 12, P_GRAV = 1, P_DIV = 6;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0, key_atk = 1'b0;
  logic [9:0] AkumaX, AkumaY;
  logic [2:0] sprite_sel, anim_frame;
  logic       facing_left, airborne;

  int vectors = 0;
  int miscompares = 0;

  int m_st, m_x, m_y, m_vy, m_cnt, m_jdir;
  bit m_face;

  always #5 vga_clk = ~vga_clk;

  akuma_move_ctrl dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_up      (key_up),
    .key_down    (key_down),
    .key_atk     (key_atk),
    .AkumaX      (AkumaX),
    .AkumaY      (AkumaY),
    .sprite_sel  (sprite_sel),
    .anim_frame  (anim_frame),
    .facing_left (facing_left),
    .airborne    (airborne)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit expired, got running expected finished");
    $fatal(1);
  end

  // ---------------- reference model (rule level) ----------------
  task automatic model_reset();
    m_st = S_IDLE; m_x = P_START_X; m_y = P_GROUND_Y; m_vy = 0;
    m_cnt = 0; m_face = 1'b0; m_jdir = 0;
  endtask

  function automatic int move_x(input int x, input int dir);
    if (dir > 0) return (x + P_SPEED > P_X_MAX) ? P_X_MAX : x + P_SPEED;
    if (dir < 0) return (x < P_SPEED) ? 0 : x - P_SPEED;
    return x;
  endfunction

  task automatic model_step(input bit l, input bit r, input bit u, input bit d, input bit a);
    int dir, ns, hdir, yn;
    dir = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
    ns = m_st;
    case (m_st)
      S_IDLE, S_WALK: begin
        if (a) ns = S_ATTACK;
        else if (u) begin
          ns = S_JUMP; m_vy = -P_JUMP_VEL;
          m_jdir = (m_st == S_WALK) ? dir : 0;
        end else if (d) ns = S_CROUCH;
        else if (dir != 0) begin
          ns = S_WALK; m_x = move_x(m_x, dir); m_face = (dir < 0);
        end else ns = S_IDLE;
      end
      S_CROUCH: ns = d ? S_CROUCH : S_IDLE;
      S_JUMP: begin
`ifdef AKUMA_AIR_CONTROL_EN
        hdir = dir;
        if (dir != 0) m_face = (dir < 0);
`else
        hdir = m_jdir;
`endif
        m_x = move_x(m_x, hdir);
        yn = m_y + m_vy;
        if (yn >= P_GROUND_Y) begin
          m_y = P_GROUND_Y; m_vy = 0; ns = S_IDLE;
        end else begin
          m_y = yn; m_vy = m_vy + P_GRAV;
        end
      end
      S_ATTACK: if (m_cnt + 1 == 4 * P_DIV) ns = S_IDLE;
      default: ns = S_IDLE;
    endcase
    m_cnt = (ns == m_st) ? m_cnt + 1 : 0;
    m_st = ns;
  endtask

  function automatic logic [27:0] mdl_vec();
    int f;
    case (m_st)
      S_IDLE, S_ATTACK: f = (m_cnt / P_DIV) % 4;
      S_WALK:           f = (m_cnt / P_DIV) % 6;
      S_JUMP:           f = (m_vy < 0) ? 0 : 1;
      default:          f = 0;
    endcase
    return {m_x[9:0], m_y[9:0], m_st[2:0], f[2:0], m_face, (m_st == S_JUMP)};
  endfunction

  function automatic logic [27:0] dut_vec();
    return {AkumaX, AkumaY, sprite_sel, anim_frame, facing_left, airborne};
  endfunction

  task automatic do_tick(input bit l, input bit r, input bit u, input bit d, input bit a);
    @(negedge vga_clk);
    key_left = l; key_right = r; key_up = u; key_down = d; key_atk = a;
    frame_tick = 1'b1;
    @(posedge vga_clk);
    #1;
    frame_tick = 1'b0;
    model_step(l, r, u, d, a);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [27:0] rst_vec;
    rst_vec = {10'd100, 10'd300, 3'd0, 3'd0, 1'b0, 1'b0};
    reset_n = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    vectors++;
    if (dut_vec() !== rst_vec) begin
      miscompares++;
      $display("FAIL reset_values: got %h expected %h", dut_vec(), rst_vec);
    end
    @(negedge vga_clk);
    reset_n = 1'b1;
    model_reset();
    @(posedge vga_clk);
    #1;
    vectors++;
    if (dut_vec() !== mdl_vec()) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_idle_anim();
    for (int k = 1; k <= 24; k++) begin
      do_tick(0, 0, 0, 0, 0);
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL idle_vec tick %0d: got %h expected %h", k, dut_vec(), mdl_vec());
      end
      if (k == 6) begin
        vectors++;
        if (anim_frame !== 3'd1) begin
          miscompares++;
          $display("FAIL idle_frame6: got %0d expected 1", anim_frame);
        end
      end
      if (k == 24) begin
        vectors++;
        if ({AkumaX, AkumaY, sprite_sel, anim_frame} !== {10'd100, 10'd300, 3'd0, 3'd0}) begin
          miscompares++;
          $display("FAIL idle_tick24: got x=%0d y=%0d sel=%0d frame=%0d expected 100 300 0 0",
                   AkumaX, AkumaY, sprite_sel, anim_frame);
        end
      end
    end
  endtask

  task automatic test_walk_clamp();
    int ex;
    for (int k = 0; k < 198; k++) begin
      do_tick(0, 1, 0, 0, 0);
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL walk_vec step %0d: got %h expected %h", k, dut_vec(), mdl_vec());
      end
    end
    for (int k = 1; k <= 3; k++) begin
      do_tick(0, 1, 0, 0, 0);
      ex = (k == 1) ? 498 : 500;
      vectors++;
      if (AkumaX !== 10'(ex) || facing_left !== 1'b0 || sprite_sel !== 3'd1) begin
        miscompares++;
        $display("FAIL walk_right_clamp %0d: got x=%0d face=%0d sel=%0d expected %0d 0 1",
                 k, AkumaX, facing_left, sprite_sel, ex);
      end
    end
    do_tick(1, 1, 0, 0, 0);
    vectors++;
    if (AkumaX !== 10'd500 || sprite_sel !== 3'd0) begin
      miscompares++;
      $display("FAIL both_dirs: got x=%0d sel=%0d expected 500 0", AkumaX, sprite_sel);
    end
    for (int k = 0; k < 252; k++) begin
      do_tick(1, 0, 0, 0, 0);
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL walk_left step %0d: got %h expected %h", k, dut_vec(), mdl_vec());
      end
    end
    vectors++;
    if (AkumaX !== 10'd0 || facing_left !== 1'b1) begin
      miscompares++;
      $display("FAIL walk_left_clamp: got x=%0d face=%0d expected 0 1", AkumaX, facing_left);
    end
  endtask

  task automatic test_jump();
    do_tick(0, 0, 0, 0, 0);
    do_tick(0, 0, 1, 0, 0);
    vectors++;
    if (airborne !== 1'b1 || AkumaY !== 10'd300 || sprite_sel !== 3'd3 || anim_frame !== 3'd0) begin
      miscompares++;
      $display("FAIL jump_takeoff: got air=%0d y=%0d sel=%0d frame=%0d expected 1 300 3 0",
               airborne, AkumaY, sprite_sel, anim_frame);
    end
    for (int k = 1; k <= 25; k++) begin
      do_tick(0, 0, 0, 0, 0);
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL jump_vec tick %0d: got %h expected %h", k, dut_vec(), mdl_vec());
      end
      if (k == 1 || k == 12 || k == 13) begin
        vectors++;
        if (AkumaY !== ((k == 1) ? 10'd288 : 10'd222)) begin
          miscompares++;
          $display("FAIL jump_y tick %0d: got %0d expected %0d", k, AkumaY, (k == 1) ? 288 : 222);
        end
      end
      if (k < 25) begin
        vectors++;
        if (anim_frame !== ((k >= 12) ? 3'd1 : 3'd0) || airborne !== 1'b1) begin
          miscompares++;
          $display("FAIL jump_frame tick %0d: got frame=%0d air=%0d expected %0d 1",
                   k, anim_frame, airborne, (k >= 12) ? 1 : 0);
        end
      end else begin
        vectors++;
        if (AkumaY !== 10'd300 || sprite_sel !== 3'd0 || airborne !== 1'b0) begin
          miscompares++;
          $display("FAIL jump_land: got y=%0d sel=%0d air=%0d expected 300 0 0",
                   AkumaY, sprite_sel, airborne);
        end
      end
    end
  endtask

  task automatic test_air_control();
    logic       exp_face;
    logic [9:0] exp_land;
`ifdef AKUMA_AIR_CONTROL_EN
    exp_face = 1'b1; exp_land = 10'd150;
`else
    exp_face = 1'b0; exp_land = 10'd200;
`endif
    for (int k = 0; k < 100; k++) do_tick(0, 1, 0, 0, 0);
    do_tick(0, 0, 0, 0, 0);
    vectors++;
    if (AkumaX !== 10'd200 || facing_left !== 1'b0) begin
      miscompares++;
      $display("FAIL air_setup: got x=%0d face=%0d expected 200 0", AkumaX, facing_left);
    end
    do_tick(0, 0, 1, 0, 0);
    for (int k = 1; k <= 25; k++) begin
      do_tick(1, 0, 0, 0, 0);
      vectors++;
      if (dut_vec() !== mdl_vec() || facing_left !== exp_face) begin
        miscompares++;
        $display("FAIL air_vec tick %0d: got %h face=%0d expected %h face=%0d",
                 k, dut_vec(), facing_left, mdl_vec(), exp_face);
      end
    end
    vectors++;
    if (AkumaX !== exp_land || sprite_sel !== 3'd0) begin
      miscompares++;
      $display("FAIL air_land_x: got x=%0d sel=%0d expected %0d 0", AkumaX, sprite_sel, exp_land);
    end
  endtask

  task automatic test_attack();
    logic [9:0] x0;
    do_tick(0, 0, 0, 0, 0);
    x0 = AkumaX;
    do_tick(0, 0, 1, 0, 1);
    vectors++;
    if (sprite_sel !== 3'd4 || anim_frame !== 3'd0 || airborne !== 1'b0) begin
      miscompares++;
      $display("FAIL attack_priority: got sel=%0d frame=%0d air=%0d expected 4 0 0",
               sprite_sel, anim_frame, airborne);
    end
    for (int k = 1; k <= 24; k++) begin
      do_tick(1, 0, 1, 0, 0);
      vectors++;
      if (k < 24) begin
        if (sprite_sel !== 3'd4 || anim_frame !== 3'(k / 6) || AkumaX !== x0) begin
          miscompares++;
          $display("FAIL attack_hold tick %0d: got sel=%0d frame=%0d x=%0d expected 4 %0d %0d",
                   k, sprite_sel, anim_frame, AkumaX, k / 6, x0);
        end
      end else begin
        if (sprite_sel !== 3'd0 || anim_frame !== 3'd0 || AkumaX !== x0) begin
          miscompares++;
          $display("FAIL attack_end: got sel=%0d frame=%0d x=%0d expected 0 0 %0d",
                   sprite_sel, anim_frame, AkumaX, x0);
        end
      end
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL attack_vec tick %0d: got %h expected %h", k, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_reset_mid_jump();
    logic [27:0] rst_vec;
    rst_vec = {10'd100, 10'd300, 3'd0, 3'd0, 1'b0, 1'b0};
    do_tick(0, 0, 1, 0, 0);
    for (int k = 0; k < 8; k++) do_tick(0, 0, 0, 0, 0);
    vectors++;
    if (airborne !== 1'b1) begin
      miscompares++;
      $display("FAIL midjump_air: got %0d expected 1", airborne);
    end
    @(posedge vga_clk);
    #2;
    reset_n = 1'b0;
    #2;
    vectors++;
    if (dut_vec() !== rst_vec) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected %h", dut_vec(), rst_vec);
    end
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    bit l, r, u, d, a;
    int gap;
    for (int i = 0; i < 1500; i++) begin
      l = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 2) == 0);
      u = ($urandom_range(0, 9) == 0);
      d = ($urandom_range(0, 5) == 0);
      a = ($urandom_range(0, 15) == 0);
      do_tick(l, r, u, d, a);
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL random_tick %0d: got %h expected %h", i, dut_vec(), mdl_vec());
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge vga_clk);
        key_left = $urandom_range(0, 1) == 1; key_right = $urandom_range(0, 1) == 1;
        key_up = $urandom_range(0, 1) == 1;   key_down = $urandom_range(0, 1) == 1;
        key_atk = $urandom_range(0, 1) == 1;
        @(posedge vga_clk);
        #1;
        vectors++;
        if (dut_vec() !== mdl_vec()) begin
          miscompares++;
          $display("FAIL random_hold %0d: got %h expected %h", i, dut_vec(), mdl_vec());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_anim();
    test_walk_clamp();
    test_jump();
    test_air_control();
    test_attack();
    test_reset_mid_jump();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
